// File: rtl/dom_pkg.sv
// Shared helpers for the domain-oriented-masking AND: share-pair counting and indexing.
package dom_pkg;

    localparam int unsigned DOM_MAX_SHARES = 5;

    // Number of unordered share pairs for a given share count.
    function automatic int unsigned npair(input int unsigned shares);
        return (shares * (shares - 1)) / 2;
    endfunction

    // Lexicographic index of pair (i,j), i<j: (0,1)=0, (0,2)=1, ..., (shares-2,shares-1)=npair-1.
    function automatic int unsigned pair_idx(input int unsigned shares,
                                             input int unsigned i,
                                             input int unsigned j);
        return (i * (2 * shares - i - 1)) / 2 + (j - i - 1);
    endfunction

endpackage

// File: rtl/dom_and_cross.sv
// One directed DOM cross-domain term: (a_i & b_j) ^ r for a single share pair.
module dom_and_cross #(
    parameter int unsigned WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] y
);

    assign y = (a & b) ^ r;

endmodule

// File: rtl/dom_and_pipe.sv
// Two-stage d-th order DOM AND with valid/ready handshake.
// Optional build macro DOM_AND_PIPE_ZEROIZE_EN clears data registers of empty stages.
module dom_and_pipe
    import dom_pkg::*;
#(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned SHARES = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [SHARES*WIDTH-1:0]        i_a,
    input  logic [SHARES*WIDTH-1:0]        i_b,
    input  logic [npair(SHARES)*WIDTH-1:0] i_r,
    input  logic                           i_valid,
    output logic                           i_ready,
    output logic [SHARES*WIDTH-1:0]        o_y,
    output logic                           o_valid,
    input  logic                           o_ready
);

    localparam int unsigned NPAIR = npair(SHARES);

    logic             s1_valid;
    logic             adv1;
    logic             adv2;
    logic             accept;

    logic [WIDTH-1:0] a_sh       [SHARES];
    logic [WIDTH-1:0] b_sh       [SHARES];
    logic [WIDTH-1:0] r_p        [NPAIR];
    logic [WIDTH-1:0] inner_d    [SHARES];
    logic [WIDTH-1:0] inner_q    [SHARES];
    logic [WIDTH-1:0] cross_lo_d [NPAIR];
    logic [WIDTH-1:0] cross_hi_d [NPAIR];
    logic [WIDTH-1:0] cross_lo_q [NPAIR];
    logic [WIDTH-1:0] cross_hi_q [NPAIR];
    logic [SHARES*WIDTH-1:0] y_d;

    assign adv2    = !o_valid || o_ready;
    assign adv1    = !s1_valid || adv2;
    assign accept  = i_valid && adv1;
    assign i_ready = adv1;

    // Split flat buses into shares; cross_lo holds (a_i&b_j)^r, cross_hi holds (a_j&b_i)^r.
    for (genvar i = 0; i < SHARES; i++) begin : g_share
        assign a_sh[i]    = i_a[i*WIDTH +: WIDTH];
        assign b_sh[i]    = i_b[i*WIDTH +: WIDTH];
        assign inner_d[i] = a_sh[i] & b_sh[i];
        for (genvar j = i + 1; j < SHARES; j++) begin : g_pair
            localparam int unsigned P = pair_idx(SHARES, i, j);
            assign r_p[P] = i_r[P*WIDTH +: WIDTH];
            dom_and_cross #(.WIDTH(WIDTH)) u_cross_lo (
                .a (a_sh[i]),
                .b (b_sh[j]),
                .r (r_p[P]),
                .y (cross_lo_d[P])
            );
            dom_and_cross #(.WIDTH(WIDTH)) u_cross_hi (
                .a (a_sh[j]),
                .b (b_sh[i]),
                .r (r_p[P]),
                .y (cross_hi_d[P])
            );
        end
    end

    // Stage 1: every term registered in its own flop before any cross-domain XOR.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            for (int k = 0; k < SHARES; k++) inner_q[k] <= '0;
            for (int k = 0; k < NPAIR; k++) begin
                cross_lo_q[k] <= '0;
                cross_hi_q[k] <= '0;
            end
        end else begin
            if (adv1) s1_valid <= accept;
            if (accept) begin
                for (int k = 0; k < SHARES; k++) inner_q[k] <= inner_d[k];
                for (int k = 0; k < NPAIR; k++) begin
                    cross_lo_q[k] <= cross_lo_d[k];
                    cross_hi_q[k] <= cross_hi_d[k];
                end
            end
`ifdef DOM_AND_PIPE_ZEROIZE_EN
            else if (adv1) begin
                for (int k = 0; k < SHARES; k++) inner_q[k] <= '0;
                for (int k = 0; k < NPAIR; k++) begin
                    cross_lo_q[k] <= '0;
                    cross_hi_q[k] <= '0;
                end
            end
`endif
        end
    end

    // Share i gathers its inner term and every cross term owned by domain i.
    always_comb begin
        y_d = '0;
        for (int i = 0; i < SHARES; i++) begin
            y_d[i*WIDTH +: WIDTH] = inner_q[i];
            for (int j = 0; j < SHARES; j++) begin
                if (j > i) begin
                    y_d[i*WIDTH +: WIDTH] = y_d[i*WIDTH +: WIDTH]
                                          ^ cross_lo_q[pair_idx(SHARES, i, j)];
                end else if (j < i) begin
                    y_d[i*WIDTH +: WIDTH] = y_d[i*WIDTH +: WIDTH]
                                          ^ cross_hi_q[pair_idx(SHARES, j, i)];
                end
            end
        end
    end

    // Stage 2: o_y only moves when a real beat advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_y     <= '0;
        end else begin
            if (adv2) o_valid <= s1_valid;
            if (adv2 && s1_valid) begin
                o_y <= y_d;
            end
`ifdef DOM_AND_PIPE_ZEROIZE_EN
            else if (adv2) begin
                o_y <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_dom_and_pipe.sv
// Scoreboard bench for dom_and_pipe: 3-share/8-bit main instance plus 2-share/1-bit legacy instance.
module tb_dom_and_pipe;

    localparam int unsigned W  = 8;
    localparam int unsigned S  = 3;
    localparam int unsigned NP = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [S*W-1:0]  a, b;
    logic [NP*W-1:0] r;
    logic            iv, irdy, ov, ordy;
    logic [S*W-1:0]  oy;

    logic [1:0] la, lb, ly;
    logic [0:0] lr;
    logic       lv, lirdy, lov, lordy;

    int checks   = 0;
    int failures = 0;
    int pops     = 0;

    logic [S*W-1:0] qy[$];
    logic [W-1:0]   qs[$];
    logic           m_s1, m_ov;
    logic [S*W-1:0] m_y;

    always #5 clk = ~clk;

    dom_and_pipe #(.WIDTH(W), .SHARES(S)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_a     (a),
        .i_b     (b),
        .i_r     (r),
        .i_valid (iv),
        .i_ready (irdy),
        .o_y     (oy),
        .o_valid (ov),
        .o_ready (ordy)
    );

    dom_and_pipe #(.WIDTH(1), .SHARES(2)) dut_l (
        .clk     (clk),
        .rst     (rst),
        .i_a     (la),
        .i_b     (lb),
        .i_r     (lr),
        .i_valid (lv),
        .i_ready (lirdy),
        .o_y     (ly),
        .o_valid (lov),
        .o_ready (lordy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] fold(input logic [S*W-1:0] x);
        return x[7:0] ^ x[15:8] ^ x[23:16];
    endfunction

    // Reference shares: y_i = a_i b_i ^ XOR_{j!=i} ((a_i b_j) ^ r_pair); for 3 shares pair(i,j) = i+j-1.
    function automatic logic [S*W-1:0] model(input logic [S*W-1:0] ma, input logic [S*W-1:0] mb,
                                             input logic [NP*W-1:0] mr);
        logic [S*W-1:0] res;
        logic [W-1:0]   ys;
        int             p;
        res = '0;
        for (int i = 0; i < 3; i++) begin
            ys = ma[i*8 +: 8] & mb[i*8 +: 8];
            for (int j = 0; j < 3; j++) begin
                if (j != i) begin
                    p  = i + j - 1;
                    ys = ys ^ (ma[i*8 +: 8] & mb[j*8 +: 8]) ^ mr[p*8 +: 8];
                end
            end
            res[i*8 +: 8] = ys;
        end
        return res;
    endfunction

    task automatic clear_model();
        m_s1 = 1'b0;
        m_ov = 1'b0;
        m_y  = '0;
        qy.delete();
        qs.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        iv  = 1'b0;
        lv  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model();
        #1;
        check("rst_o_valid", 64'(ov), 64'(0));
        check("rst_o_y", 64'(oy), 64'(0));
        check("rst_i_ready", 64'(irdy), 64'(1));
    endtask

    // One clock of stimulus: fresh random data, model-predicted handshake, then edge.
    task automatic step(input logic v, input logic rdy);
        logic adv1, adv2, acc, pop;
        a    = 24'($urandom);
        b    = 24'($urandom);
        r    = 24'($urandom);
        iv   = v;
        ordy = rdy;
        #1;
        adv2 = !m_ov || rdy;
        adv1 = !m_s1 || adv2;
        acc  = v && adv1;
        pop  = m_ov && rdy;
        check("i_ready", 64'(irdy), 64'(adv1));
        check("o_valid", 64'(ov), 64'(m_ov));
        check("o_y", 64'(oy), 64'(m_y));
        if (pop) check("y_sum", 64'(fold(oy)), 64'(qs[0]));
        if (acc) begin
            qy.push_back(model(a, b, r));
            qs.push_back(fold(a) & fold(b));
        end
        @(posedge clk);
        #1;
        if (adv2) begin
            if (m_s1) m_y = qy[m_ov ? 1 : 0];
`ifdef DOM_AND_PIPE_ZEROIZE_EN
            else m_y = '0;
`endif
        end
        if (pop) begin
            void'(qy.pop_front());
            void'(qs.pop_front());
            pops++;
        end
        if (adv2) m_ov = m_s1;
        if (adv1) m_s1 = acc;
    endtask

    initial begin
        int pops0;
        a = '0; b = '0; r = '0; iv = 1'b0; ordy = 1'b1;
        la = '0; lb = '0; lr = '0; lv = 1'b0; lordy = 1'b1;
        rst = 1'b0;
        clear_model();

        do_reset();
        check("rst_l_o_valid", 64'(lov), 64'(0));
        check("rst_l_o_y", 64'(ly), 64'(0));

        // Legacy 2-share: a0=1,a1=0,b0=1,b1=1,r=1 -> y0=1,y1=1.
        la = 2'b01; lb = 2'b11; lr = 1'b1; lv = 1'b1; lordy = 1'b1;
        #1;
        check("legacy_i_ready", 64'(lirdy), 64'(1));
        @(posedge clk);
        #1;
        lv = 1'b0;
        check("legacy_valid_c1", 64'(lov), 64'(0));
        @(posedge clk);
        #1;
        check("legacy_valid_c2", 64'(lov), 64'(1));
        check("legacy_y", 64'(ly), 64'(2'b11));
        check("legacy_sum", 64'(ly[0] ^ ly[1]), 64'(0));

        do_reset();

        // Continuous random stream at full rate.
        for (int k = 0; k < 20; k++) step(1'b1, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1);

        // Backpressure: three beats issued, then five stalled cycles with changing inputs.
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1);
        check("bp_drained", 64'(qy.size()), 64'(0));

        // Idle cycles with toggling randomness must not disturb any register.
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1);

        // Reset with two beats in flight, then one beat with 2-cycle latency.
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        do_reset();
        step(1'b1, 1'b1);
        check("post_rst_c1_valid", 64'(ov), 64'(0));
        step(1'b0, 1'b1);
        check("post_rst_c2_valid", 64'(ov), 64'(1));
        step(1'b0, 1'b1);

        // Full pipeline swapping a beat in and out every cycle.
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        pops0 = pops;
        for (int k = 0; k < 10; k++) step(1'b1, 1'b1);
        check("full_rate_pops", 64'(pops - pops0), 64'(10));
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1);
        check("final_drained", 64'(qy.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dom_and_pipe.md
Name: dom_and_pipe

Overview:
- Parametrised d-th order Domain-Oriented-Masking (DOM) AND over WIDTH-bit operands split into SHARES Boolean shares.
- Two-stage registered pipeline with valid/ready handshake; successor of the fixed 2-share, 1-bit masked AND with registered outputs.
- Output registers are kept so PROLEAD evaluation still sees registered shares.
- Used as the nonlinear primitive in masked S-box datapaths.

Parameters:
- WIDTH, 1, bits per share (bitwise-parallel AND lanes)
- SHARES, 2, number of shares (masking order d = SHARES-1); legal 2..5
- NPAIR, SHARES*(SHARES-1)/2, derived; number of share pairs (localparam, not overridable)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- i_a  in  SHARES*WIDTH  shares of a; share k at bits [k*WIDTH +: WIDTH]
- i_b  in  SHARES*WIDTH  shares of b, same layout
- i_r  in  NPAIR*WIDTH  fresh randomness; pair p at [p*WIDTH +: WIDTH]
- i_valid  in  1  input beat valid
- i_ready  out  1  block can accept input this cycle
- o_y  out  SHARES*WIDTH  shares of y = a & b
- o_valid  out  1  o_y valid
- o_ready  in  1  downstream accepts o_y

Behaviour:
- Reset (rst=1 at posedge): s1_valid=0, o_valid=0, o_y=0, all stage-1 term registers=0. i_ready is high in the cycle after reset.
- Pair index p enumerates (i,j), i<j, lexicographically: (0,1)=0, (0,2)=1, …, (SHARES-2,SHARES-1)=NPAIR-1.
- Stage 1 (on accept):
  - inner[i] <= a_i & b_i.
  - For each pair p=(i,j): cross[i][j] <= (a_i & b_j) ^ r_p and cross[j][i] <= (a_j & b_i) ^ r_p.
  - All terms are registered separately. No XOR across domains before this register.
- Stage 2 (on advance):
  - o_y share i <= inner[i] ^ XOR over j≠i of cross[i][j].
  - Sum of output shares = a & b, where a = XOR of i_a shares and b = XOR of i_b shares.
- Handshake:
  - adv2 = !o_valid | o_ready.
  - adv1 = !s1_valid | adv2.
  - i_ready = adv1, combinational from registered state and o_ready.
  - Input accepted when i_valid & i_ready. i_r is sampled only on accept and is single-use.
- Latency 2 cycles from accept to o_valid with no backpressure. Throughput 1 beat per cycle.
- Stall: while a stage does not advance, its registers hold. No register of a stalled stage may toggle; this is security relevant.
- Full pipeline with o_ready=0: i_ready=0. Data presented on i_a/i_b/i_r is ignored and must not reach any register.
- Simultaneous output pop and input accept while full: both occur in the same cycle, no bubble.
- rst mid-transfer: in-flight beats are dropped and o_valid=0 next cycle. Upstream must re-present them.
- o_y is changed only by a stage-2 advance with s1_valid=1. When s1_valid=0 and adv2=1, o_valid is cleared and o_y is left unchanged.

Optional Feature:
- Macro: DOM_AND_PIPE_ZEROIZE_EN.
- Defined:
  - Any stage whose valid is 0 at a clock edge loads 0 into its data registers (stage 1 when not accepting; o_y when no stage-2 beat).
  - This removes stale shares and prevents recombination leakage between beats.
- Undefined: data registers of empty stages hold their last value.

Decomposition:
- Shared package dom_pkg holds:
  - function npair(shares) returning SHARES*(SHARES-1)/2;
  - function pair_idx(i,j) giving the lexicographic index;
  - constant DOM_MAX_SHARES = 5.
- One natural sub-module: dom_and_cross. It produces the combinational cross term (a_i & b_j) ^ r for one share pair and one direction, and is instantiated 2*NPAIR times.
- Pipeline control stays in the top module.

Test Plan:
- Legacy equivalence: SHARES=2, WIDTH=1; a0=1,a1=0,b0=1,b1=1,r=1, i_valid=1, o_ready=1 -> o_valid after 2 cycles, y0^y1=0 (a=1, b=0); y0=1, y1=1.
- Exhaustive functional check: SHARES=3, WIDTH=8; random a,b,r with o_ready=1 -> every output beat satisfies XOR of shares = a&b; one beat per cycle; i_ready constantly 1.
- Backpressure: o_ready=0 for 5 cycles after 3 beats issued -> i_ready=0 from cycle 2; o_y and stage registers bit-stable; beats emerge in order once o_ready=1.
- Randomness consumption: hold i_valid=0 while toggling i_r -> no register changes. Under DOM_AND_PIPE_ZEROIZE_EN, all data registers read 0 after 2 idle cycles.
- Reset mid-operation: rst=1 with 2 beats in flight -> o_valid=0 and o_y=0 next cycle; the next accepted beat appears 2 cycles after acceptance.
- Full-throughput swap: pipeline full, o_ready=1 and i_valid=1 every cycle for 10 cycles -> 10 consecutive outputs with no bubble.
